// File: rtl/sat_add_pkg.sv
// Shared mode encoding and signed-overflow helper for the saturating add/sub pipe.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package sat_add_pkg;

    typedef enum logic [1:0] {
        PACKED_ADD = 2'b00,
        SAT_ADD    = 2'b01,
        SAT_SUB    = 2'b10,
        WRAP_ADD   = 2'b11
    } sat_mode_t;

    // Two's-complement overflow: operands agree in sign, result does not.
    function automatic logic sgn_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

endpackage

// File: rtl/sat_lane_cla.sv
// One LANE_W-bit carry-lookahead lane: group P/G plus carry-select sums for cin=0 and cin=1.
// Latency: combinational.
// Backpressure: none; the parent pipe owns all flow control.
module sat_lane_cla #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
    output logic              p,
    output logic              g,
    output logic [LANE_W-1:0] sum0,
    output logic [LANE_W-1:0] sum1
);

    logic [LANE_W-1:0] pb;
    logic [LANE_W-1:0] gb;
    logic              c0;
    logic              c1;

    assign pb = a ^ b;
    assign gb = a & b;

    always_comb begin
        sum0 = '0;
        sum1 = '0;
        c0   = 1'b0;
        c1   = 1'b1;
        for (int k = 0; k < LANE_W; k++) begin
            sum0[k] = pb[k] ^ c0;
            sum1[k] = pb[k] ^ c1;
            c0      = gb[k] | (pb[k] & c0);
            c1      = gb[k] | (pb[k] & c1);
        end
        // Group generate is the lane carry-out with cin=0.
        g = c0;
        p = &pb;
    end

endmodule

// File: rtl/sat_addsub_pipe.sv
// Two-stage packed/saturating adder-subtractor; optional sticky overflow under SAT_ADD_STICKY_EN.
// Latency: 2 register stages (S1 lane P/G + carry-select sums, S2 carry resolve + saturation).
// Backpressure: valid/ready; in_ready = ~s1_valid | s2_adv, full throughput with no bubbles.
module sat_addsub_pipe
    import sat_add_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             cout
`ifdef SAT_ADD_STICKY_EN
    ,
    output logic             sticky_ovfl,
    input  logic             sticky_clr
`endif
);

    localparam int NL = WIDTH / LANE_W;

    sat_mode_t         mode_in;
    logic [WIDTH-1:0]  b_eff;
    logic [NL-1:0]     lp, lg, asgn, bsgn;
    logic [WIDTH-1:0]  ls0, ls1;

    assign mode_in = sat_mode_t'(mode);
    // Subtraction is a + ~b + 1; the +1 enters as the lane-0 carry in S2.
    assign b_eff   = (mode_in == SAT_SUB) ? ~b : b;

    for (genvar i = 0; i < NL; i++) begin : g_lane
        sat_lane_cla #(.LANE_W(LANE_W)) u_lane (
            .a    (a[i*LANE_W +: LANE_W]),
            .b    (b_eff[i*LANE_W +: LANE_W]),
            .p    (lp[i]),
            .g    (lg[i]),
            .sum0 (ls0[i*LANE_W +: LANE_W]),
            .sum1 (ls1[i*LANE_W +: LANE_W])
        );
        assign asgn[i] = a[i*LANE_W + LANE_W - 1];
        assign bsgn[i] = b_eff[i*LANE_W + LANE_W - 1];
    end

    logic             s1_valid_q, s1_valid_d;
    logic [NL-1:0]    s1_p_q, s1_p_d, s1_g_q, s1_g_d;
    logic [NL-1:0]    s1_asgn_q, s1_asgn_d, s1_bsgn_q, s1_bsgn_d;
    logic [WIDTH-1:0] s1_sum0_q, s1_sum0_d, s1_sum1_q, s1_sum1_d;
    sat_mode_t        s1_mode_q, s1_mode_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             ovfl_q, ovfl_d;
    logic             cout_q, cout_d;

    logic             s2_adv, in_fire, s1_to_s2;
    logic [NL-1:0]    lane_cin;
    logic             c;
    logic [WIDTH-1:0] raw, res_sum;
    logic             res_ovfl, res_cout;

    assign s2_adv   = ~out_valid_q | out_ready;
    assign in_ready = ~rst & (~s1_valid_q | s2_adv);
    assign in_fire  = in_valid & in_ready;
    assign s1_to_s2 = s1_valid_q & s2_adv;

    // S2: lane-level lookahead, carry-select, then saturation.
    always_comb begin
        lane_cin = '0;
        raw      = '0;
        c        = (s1_mode_q == SAT_SUB);
        for (int i = 0; i < NL; i++) begin
            lane_cin[i] = (s1_mode_q == PACKED_ADD) ? 1'b0 : c;
            c           = s1_g_q[i] | (s1_p_q[i] & c);
        end
        for (int i = 0; i < NL; i++) begin
            raw[i*LANE_W +: LANE_W] = lane_cin[i] ? s1_sum1_q[i*LANE_W +: LANE_W]
                                                  : s1_sum0_q[i*LANE_W +: LANE_W];
        end
        res_sum  = raw;
        res_ovfl = 1'b0;
        res_cout = c;
        case (s1_mode_q)
            PACKED_ADD: begin
                res_cout = s1_g_q[NL-1];
                for (int i = 0; i < NL; i++) begin
                    if (sgn_ovf(s1_asgn_q[i], s1_bsgn_q[i], raw[i*LANE_W + LANE_W - 1])) begin
                        res_sum[i*LANE_W +: LANE_W] = {s1_asgn_q[i], {(LANE_W-1){~s1_asgn_q[i]}}};
                        res_ovfl = 1'b1;
                    end
                end
            end
            SAT_ADD, SAT_SUB: begin
                if (sgn_ovf(s1_asgn_q[NL-1], s1_bsgn_q[NL-1], raw[WIDTH-1])) begin
                    res_sum  = {s1_asgn_q[NL-1], {(WIDTH-1){~s1_asgn_q[NL-1]}}};
                    res_ovfl = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_p_d      = s1_p_q;
        s1_g_d      = s1_g_q;
        s1_asgn_d   = s1_asgn_q;
        s1_bsgn_d   = s1_bsgn_q;
        s1_sum0_d   = s1_sum0_q;
        s1_sum1_d   = s1_sum1_q;
        s1_mode_d   = s1_mode_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        ovfl_d      = ovfl_q;
        cout_d      = cout_q;
        if (in_ready) s1_valid_d = in_valid;
        if (in_fire) begin
            s1_p_d    = lp;
            s1_g_d    = lg;
            s1_asgn_d = asgn;
            s1_bsgn_d = bsgn;
            s1_sum0_d = ls0;
            s1_sum1_d = ls1;
            s1_mode_d = mode_in;
        end
        if (s2_adv) out_valid_d = s1_valid_q;
        if (s1_to_s2) begin
            sum_d  = res_sum;
            ovfl_d = res_ovfl;
            cout_d = res_cout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            ovfl_q      <= 1'b0;
            cout_q      <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            ovfl_q      <= ovfl_d;
            cout_q      <= cout_d;
        end
    end

    // S1 payload is qualified by s1_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        s1_p_q    <= s1_p_d;
        s1_g_q    <= s1_g_d;
        s1_asgn_q <= s1_asgn_d;
        s1_bsgn_q <= s1_bsgn_d;
        s1_sum0_q <= s1_sum0_d;
        s1_sum1_q <= s1_sum1_d;
        s1_mode_q <= s1_mode_d;
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign ovfl      = ovfl_q;
    assign cout      = cout_q;

`ifdef SAT_ADD_STICKY_EN
    logic sticky_q, sticky_d;

    // Set wins over clear so an overflow transferring alongside a clear is not lost.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_clr) sticky_d = 1'b0;
        if (out_valid_q && out_ready && ovfl_q) sticky_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) sticky_q <= 1'b0;
        else     sticky_q <= sticky_d;
    end

    assign sticky_ovfl = sticky_q;
`endif

endmodule

// File: tb/tb_sat_addsub_pipe.sv
// Directed bench for sat_addsub_pipe (WIDTH=16, LANE_W=4): mode vectors, backpressure, reset flush, sticky.
module tb_sat_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        ovfl;
    logic        cout;
`ifdef SAT_ADD_STICKY_EN
    logic        sticky_ovfl;
    logic        sticky_clr;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sat_addsub_pipe #(.WIDTH(16), .LANE_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovfl      (ovfl),
        .cout      (cout)
`ifdef SAT_ADD_STICKY_EN
        ,
        .sticky_ovfl (sticky_ovfl),
        .sticky_clr  (sticky_clr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic [1:0] vm, input logic [15:0] es,
                           input logic eo, input logic ec);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        a = va; b = vb; mode = vm; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".sum"},       {16'd0, sum},       {16'd0, es});
        chk({tag, ".ovfl"},      {31'd0, ovfl},      {31'd0, eo});
        chk({tag, ".cout"},      {31'd0, cout},      {31'd0, ec});
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; mode = 2'b00;
`ifdef SAT_ADD_STICKY_EN
        sticky_clr = 1'b0;
`endif
        tick; tick;
        chk("rst.in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.sum",       {16'd0, sum},       32'd0);
        chk("rst.ovfl",      {31'd0, ovfl},      32'd0);
        chk("rst.cout",      {31'd0, cout},      32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", {31'd0, in_ready}, 32'd1);

        run_one("pk_sat",    16'h7777, 16'h1111, 2'b00, 16'h7777, 1'b1, 1'b0);
        run_one("pk_plain",  16'h1234, 16'h1111, 2'b00, 16'h2345, 1'b0, 1'b0);
        run_one("pk_neg",    16'h8888, 16'h8888, 2'b00, 16'h8888, 1'b1, 1'b1);
        run_one("pk_nocar",  16'hF00F, 16'h1001, 2'b00, 16'h0000, 1'b0, 1'b1);
        run_one("sa_pos",    16'h7FFF, 16'h0001, 2'b01, 16'h7FFF, 1'b1, 1'b0);
        run_one("sa_neg",    16'h8000, 16'hFFFF, 2'b01, 16'h8000, 1'b1, 1'b1);
        run_one("sa_carry",  16'h00FF, 16'h0001, 2'b01, 16'h0100, 1'b0, 1'b0);
        run_one("ss_neg",    16'h8000, 16'h0001, 2'b10, 16'h8000, 1'b1, 1'b1);
        run_one("ss_plain",  16'h0005, 16'h0003, 2'b10, 16'h0002, 1'b0, 1'b1);
        run_one("ss_pos",    16'h7FFF, 16'hFFFF, 2'b10, 16'h7FFF, 1'b1, 1'b0);
        run_one("wr_wrap",   16'hFFFF, 16'h0001, 2'b11, 16'h0000, 1'b0, 1'b1);
        run_one("wr_novf",   16'h7FFF, 16'h0001, 2'b11, 16'h8000, 1'b0, 1'b0);
        tick;

        // Backpressure: three back-to-back inputs while the sink stalls.
        out_ready = 1'b0; mode = 2'b11; b = 16'h0001;
        a = 16'h0001; in_valid = 1'b1;
        tick;
        a = 16'h0002;
        tick;
        chk("bp.out_valid", {31'd0, out_valid}, 32'd1);
        chk("bp.first",     {16'd0, sum},       32'h0002);
        chk("bp.in_ready",  {31'd0, in_ready},  32'd0);
        a = 16'h0003;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("bp.hold_sum",   {16'd0, sum},       32'h0002);
            chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.hold_rdy",   {31'd0, in_ready},  32'd0);
        end
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        chk("bp.second",   {16'd0, sum},       32'h0003);
        tick;
        chk("bp.third",    {16'd0, sum},       32'h0004);
        chk("bp.third_v",  {31'd0, out_valid}, 32'd1);
        tick;
        chk("bp.drained",  {31'd0, out_valid}, 32'd0);

        // Reset with both stages occupied.
        out_ready = 1'b0; mode = 2'b11; a = 16'h0010; b = 16'h0010; in_valid = 1'b1;
        tick;
        a = 16'h0030;
        tick;
        in_valid = 1'b0;
        chk("rf.full", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rf.rdy_in_rst", {31'd0, in_ready}, 32'd0);
        tick;
        rst = 1'b0;
        chk("rf.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rf.sum",       {16'd0, sum},       32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            if (out_valid) seen++;
        end
        chk("rf.no_stale", seen, 32'd0);

`ifdef SAT_ADD_STICKY_EN
        run_one("st_set", 16'h7FFF, 16'h0001, 2'b01, 16'h7FFF, 1'b1, 1'b0);
        tick;
        chk("st.set", {31'd0, sticky_ovfl}, 32'd1);
        sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        chk("st.clr", {31'd0, sticky_ovfl}, 32'd0);
        out_ready = 1'b0; mode = 2'b01; a = 16'h7FFF; b = 16'h0001; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk("st.held", {31'd0, sticky_ovfl}, 32'd0);
        out_ready = 1'b1; sticky_clr = 1'b1;
        tick;
        sticky_clr = 1'b0;
        chk("st.set_wins", {31'd0, sticky_ovfl}, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
